// File: rtl/eth_axis_tx_framer_if.sv
// Byte-wide AXI-stream link between the frame source and the MAC TX FIFO sink.
// tuser=1 marks a bad frame that the downstream frame FIFO drops.
interface eth_axis_tx_framer_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic       tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/eth_axis_tx_framer.sv
// Frame source for the MAC TX stream: host fills a byte buffer, pulses tx_start, frame streams out.
// Optional abort support is enabled by defining ETH_TX_FRAMER_ABORT_EN.
module eth_axis_tx_framer #(
    parameter int unsigned BUF_ADDR_WIDTH = 11,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                      logic_clk,
    input  logic                      logic_rst_n,
    input  logic                      wr_en,
    input  logic [BUF_ADDR_WIDTH-1:0] wr_addr,
    input  logic [7:0]                wr_data,
    input  logic [BUF_ADDR_WIDTH:0]   tx_len,
    input  logic                      tx_start,
`ifdef ETH_TX_FRAMER_ABORT_EN
    input  logic                      tx_abort,
`endif
    output logic                      tx_busy,
    output logic                      tx_done,
    output logic [CNT_WIDTH-1:0]      tx_frame_count,
    eth_axis_tx_framer_if.master      m_axis
);

    localparam int unsigned DEPTH = 2 ** BUF_ADDR_WIDTH;
    localparam int unsigned LW    = BUF_ADDR_WIDTH + 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND} state_t;

    state_t               state_q, state_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [LW-1:0]        len_q, len_d;
    logic [LW-1:0]        rd_addr_q, rd_addr_d;
    logic                 ram_v_q, ram_v_d;
    logic                 ram_last_q, ram_last_d;
    logic [7:0]           rd_data_q;
    logic [7:0]           out_data_q, out_data_d;
    logic                 out_v_q, out_v_d;
    logic                 out_last_q, out_last_d;
    logic                 out_user_q, out_user_d;
    logic [7:0]           skid_data_q, skid_data_d;
    logic                 skid_v_q, skid_v_d;
    logic                 skid_last_q, skid_last_d;
    logic                 flush_q, flush_d;
    logic                 abort_req_q, abort_req_d;
    logic                 abort_pend_c;
    logic                 issue_c;
    logic                 fire_c;
    logic [1:0]           occ_c;

    logic [7:0] buf_mem [DEPTH];

`ifdef ETH_TX_FRAMER_ABORT_EN
    // A request raised this cycle already applies to the beat being loaded now.
    assign abort_pend_c = abort_req_q | (tx_abort & busy_q);
`else
    assign abort_pend_c = 1'b0;
`endif

    // Frame buffer: writes only while idle, synchronous read with one cycle latency.
    always_ff @(posedge logic_clk) begin
        if (wr_en && !busy_q) begin
            buf_mem[wr_addr] <= wr_data;
        end
        if (issue_c) begin
            rd_data_q <= buf_mem[rd_addr_q[BUF_ADDR_WIDTH-1:0]];
        end
    end

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        count_d     = count_q;
        len_d       = len_q;
        rd_addr_d   = rd_addr_q;
        ram_v_d     = 1'b0;
        ram_last_d  = ram_last_q;
        out_data_d  = out_data_q;
        out_v_d     = out_v_q;
        out_last_d  = out_last_q;
        out_user_d  = out_user_q;
        skid_data_d = skid_data_q;
        skid_v_d    = skid_v_q;
        skid_last_d = skid_last_q;
        flush_d     = flush_q;
        abort_req_d = abort_req_q;
        issue_c     = 1'b0;
        fire_c      = out_v_q & m_axis.tready;
        // Beats that will still be held after this cycle (output + skid + read in flight).
        occ_c       = 2'(out_v_q) + 2'(skid_v_q) + 2'(ram_v_q) - 2'(fire_c);

        case (state_q)
            S_IDLE: begin
                if (tx_start && (tx_len != '0)) begin
                    len_d       = (tx_len > LW'(DEPTH)) ? LW'(DEPTH) : tx_len;
                    rd_addr_d   = '0;
                    busy_d      = 1'b1;
                    flush_d     = 1'b0;
                    abort_req_d = 1'b0;
                    state_d     = S_FETCH;
                end
            end
            S_FETCH: state_d = S_SEND;
            default: ;
        endcase

        if (state_q != S_IDLE) begin
            if (!flush_q && (rd_addr_q < len_q) && (occ_c < 2'd2)) begin
                issue_c   = 1'b1;
                rd_addr_d = rd_addr_q + LW'(1);
            end
            ram_v_d    = issue_c;
            ram_last_d = (rd_addr_q == (len_q - LW'(1)));

            if (abort_pend_c && !flush_q) begin
                abort_req_d = 1'b1;
            end

            if (!flush_q) begin
                if (fire_c || !out_v_q) begin
                    if (skid_v_q) begin
                        out_data_d  = skid_data_q;
                        out_last_d  = skid_last_q;
                        out_v_d     = 1'b1;
                        skid_v_d    = ram_v_q;
                        skid_data_d = rd_data_q;
                        skid_last_d = ram_last_q;
                    end else begin
                        out_data_d  = rd_data_q;
                        out_last_d  = ram_last_q;
                        out_v_d     = ram_v_q;
                    end
                    out_user_d = 1'b0;
                    // Abort turns the freshly loaded beat into a bad-frame terminator.
                    if (abort_pend_c && (skid_v_q || ram_v_q)) begin
                        out_last_d  = 1'b1;
                        out_user_d  = 1'b1;
                        skid_v_d    = 1'b0;
                        flush_d     = 1'b1;
                        abort_req_d = 1'b0;
                    end
                end else if (ram_v_q) begin
                    skid_data_d = rd_data_q;
                    skid_last_d = ram_last_q;
                    skid_v_d    = 1'b1;
                end
            end else if (fire_c) begin
                out_v_d = 1'b0;
            end

            if (fire_c && out_last_q) begin
                state_d     = S_IDLE;
                busy_d      = 1'b0;
                done_d      = 1'b1;
                out_v_d     = 1'b0;
                out_user_d  = 1'b0;
                skid_v_d    = 1'b0;
                flush_d     = 1'b0;
                abort_req_d = 1'b0;
                if (!out_user_q) begin
                    count_d = count_q + CNT_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge logic_clk or negedge logic_rst_n) begin
        if (!logic_rst_n) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            count_q     <= '0;
            len_q       <= '0;
            rd_addr_q   <= '0;
            ram_v_q     <= 1'b0;
            ram_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_v_q     <= 1'b0;
            out_last_q  <= 1'b0;
            out_user_q  <= 1'b0;
            skid_data_q <= '0;
            skid_v_q    <= 1'b0;
            skid_last_q <= 1'b0;
            flush_q     <= 1'b0;
            abort_req_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            count_q     <= count_d;
            len_q       <= len_d;
            rd_addr_q   <= rd_addr_d;
            ram_v_q     <= ram_v_d;
            ram_last_q  <= ram_last_d;
            out_data_q  <= out_data_d;
            out_v_q     <= out_v_d;
            out_last_q  <= out_last_d;
            out_user_q  <= out_user_d;
            skid_data_q <= skid_data_d;
            skid_v_q    <= skid_v_d;
            skid_last_q <= skid_last_d;
            flush_q     <= flush_d;
            abort_req_q <= abort_req_d;
        end
    end

    assign tx_busy        = busy_q;
    assign tx_done        = done_q;
    assign tx_frame_count = count_q;
    assign m_axis.tdata   = out_data_q;
    assign m_axis.tvalid  = out_v_q;
    assign m_axis.tlast   = out_last_q;
    assign m_axis.tuser   = out_user_q;

endmodule

// File: tb/tb_eth_axis_tx_framer.sv
// Directed bench for eth_axis_tx_framer; abort scenario runs only when ETH_TX_FRAMER_ABORT_EN is defined.
module tb_eth_axis_tx_framer;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;
    logic [11:0] tx_len;
    logic        tx_start;
`ifdef ETH_TX_FRAMER_ABORT_EN
    logic        tx_abort;
`endif
    logic        tx_busy;
    logic        tx_done;
    logic [15:0] tx_frame_count;

    eth_axis_tx_framer_if m_axis ();

    eth_axis_tx_framer dut (
        .logic_clk      (clk),
        .logic_rst_n    (rst_n),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .tx_len         (tx_len),
        .tx_start       (tx_start),
`ifdef ETH_TX_FRAMER_ABORT_EN
        .tx_abort       (tx_abort),
`endif
        .tx_busy        (tx_busy),
        .tx_done        (tx_done),
        .tx_frame_count (tx_frame_count),
        .m_axis         (m_axis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_count = 0;

    logic [7:0] ref_mem [2048];
    logic [7:0] cap_data [4096];
    logic       cap_last [4096];
    logic       cap_user [4096];
    int cap_n, cap_viol, cap_done_n, cap_done_cyc, cap_first, cap_last_hs;
    logic cap_busy0, cap_busy_at_done;
    bit cap_timeout;

    task automatic write_range(input int base, input int n, input int mul, input int add);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_addr = 11'(base + i);
            wr_data = 8'((i * mul + add) & 255);
            ref_mem[base + i] = 8'((i * mul + add) & 255);
            @(posedge clk); #1;
        end
        wr_en = 1'b0;
    endtask

    task automatic start_frame(input int len);
        tx_len   = 12'(len);
        tx_start = 1'b1;
        @(posedge clk); #1;
        tx_start = 1'b0;
    endtask

    // Records every handshaken beat plus timing and hold-stability information.
    task automatic capture(input int budget, input bit rnd_ready, input int abort_after, input bit busy_poke);
        bit stalled = 0;
        bit fin = 0;
        bit rdy;
        logic [7:0] pd = '0;
        logic pl = 1'b0, pu = 1'b0;
        int abort_cyc = -1;
        cap_n = 0; cap_viol = 0; cap_done_n = 0; cap_done_cyc = -1; cap_first = -1;
        cap_last_hs = -1; cap_busy0 = 1'b0; cap_busy_at_done = 1'b1; cap_timeout = 0;
        for (int c = 0; c < budget && !fin; c++) begin
            if (c == 0) cap_busy0 = tx_busy;
            if (tx_done) begin
                cap_done_n++;
                if (cap_done_cyc < 0) begin cap_done_cyc = c; cap_busy_at_done = tx_busy; end
            end
            if (stalled && (m_axis.tvalid !== 1'b1 || m_axis.tdata !== pd ||
                            m_axis.tlast !== pl || m_axis.tuser !== pu)) cap_viol++;
            if (m_axis.tvalid && cap_first < 0) cap_first = c;
            rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            m_axis.tready = rdy;
`ifdef ETH_TX_FRAMER_ABORT_EN
            tx_abort = (c == abort_cyc);
`endif
            if (busy_poke && c == 3) begin
                wr_en = 1'b1; wr_addr = 11'd5; wr_data = 8'hFF; tx_start = 1'b1; tx_len = 12'd8;
            end else begin
                wr_en = 1'b0; tx_start = 1'b0;
            end
            if (m_axis.tvalid && rdy && cap_n < 4096) begin
                cap_data[cap_n] = m_axis.tdata;
                cap_last[cap_n] = m_axis.tlast;
                cap_user[cap_n] = m_axis.tuser;
                if (cap_n == abort_after) abort_cyc = c + 1;
                if (m_axis.tlast) cap_last_hs = c;
                cap_n++;
            end
            stalled = m_axis.tvalid && !rdy;
            pd = m_axis.tdata; pl = m_axis.tlast; pu = m_axis.tuser;
            if (cap_done_cyc >= 0 && c >= cap_done_cyc + 3) fin = 1;
            @(posedge clk); #1;
        end
        if (!fin) cap_timeout = 1;
        m_axis.tready = 1'b0;
        wr_en = 1'b0;
        tx_start = 1'b0;
`ifdef ETH_TX_FRAMER_ABORT_EN
        tx_abort = 1'b0;
`endif
    endtask

    task automatic test_reset;
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; tx_len = '0; tx_start = 1'b0;
        m_axis.tready = 1'b0;
`ifdef ETH_TX_FRAMER_ABORT_EN
        tx_abort = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({m_axis.tvalid, m_axis.tlast, m_axis.tuser, tx_busy, tx_done} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl got %b exp 00000",
                {m_axis.tvalid, m_axis.tlast, m_axis.tuser, tx_busy, tx_done});
        end
        n_tests++;
        if (m_axis.tdata !== 8'h00 || tx_frame_count !== 16'd0) begin
            n_fail++; $display("FAIL reset_data tdata=%h count=%0d exp 0/0", m_axis.tdata, tx_frame_count);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        int derr = 0, lerr = 0;
        write_range(0, 60, 1, 0);
        start_frame(60);
        capture(200, 1'b0, -1, 1'b0);
        exp_count++;
        for (int i = 0; i < cap_n; i++) begin
            if (cap_data[i] !== 8'(i)) derr++;
            if (cap_last[i] !== (i == 59)) lerr++;
        end
        n_tests++; if (cap_n !== 60 || cap_timeout) begin n_fail++; $display("FAIL basic_beats got %0d exp 60 (timeout=%0d)", cap_n, cap_timeout); end
        n_tests++; if (derr !== 0) begin n_fail++; $display("FAIL basic_data got %0d bad bytes exp 0", derr); end
        n_tests++; if (lerr !== 0) begin n_fail++; $display("FAIL basic_tlast got %0d misplaced exp 0", lerr); end
        n_tests++; if (cap_busy0 !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b exp 1", cap_busy0); end
        n_tests++; if (cap_first !== 2) begin n_fail++; $display("FAIL basic_first_valid got %0d exp 2", cap_first); end
        n_tests++; if (cap_last_hs - cap_first !== 59) begin n_fail++; $display("FAIL basic_b2b got %0d exp 59", cap_last_hs - cap_first); end
        n_tests++; if (cap_done_cyc - cap_last_hs !== 1 || cap_done_n !== 1) begin n_fail++; $display("FAIL basic_done got delay %0d pulses %0d exp 1/1", cap_done_cyc - cap_last_hs, cap_done_n); end
        n_tests++; if (cap_busy_at_done !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end got %b exp 0", cap_busy_at_done); end
        n_tests++; if (tx_frame_count !== 16'(exp_count)) begin n_fail++; $display("FAIL basic_count got %0d exp %0d", tx_frame_count, exp_count); end
    endtask

    task automatic test_stall;
        int derr = 0, lerr = 0;
        start_frame(60);
        capture(1000, 1'b1, -1, 1'b0);
        exp_count++;
        for (int i = 0; i < cap_n; i++) begin
            if (cap_data[i] !== 8'(i)) derr++;
            if (cap_last[i] !== (i == 59)) lerr++;
        end
        n_tests++; if (cap_n !== 60 || cap_timeout) begin n_fail++; $display("FAIL stall_beats got %0d exp 60", cap_n); end
        n_tests++; if (derr !== 0 || lerr !== 0) begin n_fail++; $display("FAIL stall_seq got %0d data/%0d tlast errors exp 0", derr, lerr); end
        n_tests++; if (cap_viol !== 0) begin n_fail++; $display("FAIL stall_hold got %0d unstable cycles exp 0", cap_viol); end
        n_tests++; if (tx_frame_count !== 16'(exp_count)) begin n_fail++; $display("FAIL stall_count got %0d exp %0d", tx_frame_count, exp_count); end
    endtask

    task automatic test_busy_access;
        int derr = 0;
        start_frame(20);
        capture(200, 1'b0, -1, 1'b1);
        exp_count++;
        for (int i = 0; i < cap_n; i++) if (cap_data[i] !== 8'(i)) derr++;
        n_tests++; if (cap_n !== 20 || derr !== 0) begin n_fail++; $display("FAIL busy_frame got %0d beats %0d errors exp 20/0", cap_n, derr); end
        n_tests++; if (cap_done_n !== 1) begin n_fail++; $display("FAIL busy_single got %0d done pulses exp 1", cap_done_n); end
        n_tests++; if (tx_frame_count !== 16'(exp_count) || tx_busy !== 1'b0) begin n_fail++; $display("FAIL busy_count got %0d busy=%b exp %0d/0", tx_frame_count, tx_busy, exp_count); end
        start_frame(8);
        capture(100, 1'b0, -1, 1'b0);
        exp_count++;
        n_tests++; if (cap_n !== 8 || cap_data[5] !== 8'h05) begin n_fail++; $display("FAIL busy_nowrite got %0d beats byte5=%h exp 8/05", cap_n, cap_data[5]); end
    endtask

`ifdef ETH_TX_FRAMER_ABORT_EN
    task automatic test_abort;
        int derr = 0;
        write_range(0, 100, 1, 0);
        start_frame(100);
        capture(300, 1'b0, 10, 1'b0);
        for (int i = 0; i < cap_n; i++) begin
            if (cap_data[i] !== 8'(i)) derr++;
            if (i < cap_n - 1 && (cap_last[i] !== 1'b0 || cap_user[i] !== 1'b0)) derr++;
        end
        n_tests++; if (!(cap_n == 12 || cap_n == 13)) begin n_fail++; $display("FAIL abort_len got %0d exp 12 or 13", cap_n); end
        n_tests++; if (cap_n > 0 && (cap_last[cap_n-1] !== 1'b1 || cap_user[cap_n-1] !== 1'b1)) begin n_fail++; $display("FAIL abort_mark got tlast=%b tuser=%b exp 1/1", cap_last[cap_n-1], cap_user[cap_n-1]); end
        n_tests++; if (derr !== 0) begin n_fail++; $display("FAIL abort_data got %0d errors exp 0", derr); end
        n_tests++; if (cap_done_n !== 1 || tx_frame_count !== 16'(exp_count)) begin n_fail++; $display("FAIL abort_done got %0d pulses count %0d exp 1/%0d", cap_done_n, tx_frame_count, exp_count); end
        start_frame(10);
        capture(100, 1'b0, -1, 1'b0);
        exp_count++;
        n_tests++; if (cap_n !== 10 || cap_user[9] !== 1'b0 || cap_last[9] !== 1'b1 || cap_data[9] !== 8'h09) begin n_fail++; $display("FAIL abort_next got %0d beats tuser=%b last=%b data=%h exp 10/0/1/09", cap_n, cap_user[9], cap_last[9], cap_data[9]); end
        n_tests++; if (tx_frame_count !== 16'(exp_count)) begin n_fail++; $display("FAIL abort_next_count got %0d exp %0d", tx_frame_count, exp_count); end
    endtask
`endif

    task automatic test_len_bounds;
        int bad = 0, derr = 0, lerr = 0;
        start_frame(0);
        for (int c = 0; c < 10; c++) begin
            if (m_axis.tvalid || tx_busy || tx_done) bad++;
            @(posedge clk); #1;
        end
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL zero_len got %0d active cycles exp 0", bad); end
        n_tests++; if (tx_frame_count !== 16'(exp_count)) begin n_fail++; $display("FAIL zero_count got %0d exp %0d", tx_frame_count, exp_count); end
        write_range(0, 2048, 7, 3);
        start_frame(4095);
        capture(2300, 1'b0, -1, 1'b0);
        exp_count++;
        for (int i = 0; i < cap_n; i++) begin
            if (cap_data[i] !== ref_mem[i]) derr++;
            if (cap_last[i] !== (i == 2047)) lerr++;
        end
        n_tests++; if (cap_n !== 2048 || cap_timeout) begin n_fail++; $display("FAIL clamp_beats got %0d exp 2048", cap_n); end
        n_tests++; if (derr !== 0 || lerr !== 0) begin n_fail++; $display("FAIL clamp_seq got %0d data/%0d tlast errors exp 0", derr, lerr); end
        n_tests++; if (cap_last_hs - cap_first !== 2047) begin n_fail++; $display("FAIL clamp_b2b got %0d exp 2047", cap_last_hs - cap_first); end
        n_tests++; if (tx_frame_count !== 16'(exp_count)) begin n_fail++; $display("FAIL clamp_count got %0d exp %0d", tx_frame_count, exp_count); end
    endtask

    task automatic test_reset_midframe;
        int hs = 0, derr = 0;
        start_frame(60);
        m_axis.tready = 1'b1;
        for (int c = 0; c < 200 && hs < 30; c++) begin
            if (m_axis.tvalid) hs++;
            @(posedge clk); #1;
        end
        n_tests++; if (hs !== 30) begin n_fail++; $display("FAIL rstmid_reach got %0d beats exp 30", hs); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (m_axis.tvalid !== 1'b0 || tx_busy !== 1'b0 || tx_frame_count !== 16'd0) begin n_fail++; $display("FAIL rstmid_state got valid=%b busy=%b count=%0d exp 0/0/0", m_axis.tvalid, tx_busy, tx_frame_count); end
        m_axis.tready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_count = 0;
        @(posedge clk); #1;
        start_frame(60);
        capture(200, 1'b0, -1, 1'b0);
        exp_count++;
        for (int i = 0; i < cap_n; i++) if (cap_data[i] !== ref_mem[i] || cap_last[i] !== (i == 59)) derr++;
        n_tests++; if (cap_n !== 60 || derr !== 0) begin n_fail++; $display("FAIL rstmid_new got %0d beats %0d errors exp 60/0", cap_n, derr); end
        n_tests++; if (tx_frame_count !== 16'(exp_count)) begin n_fail++; $display("FAIL rstmid_count got %0d exp %0d", tx_frame_count, exp_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_busy_access();
`ifdef ETH_TX_FRAMER_ABORT_EN
        test_abort();
`endif
        test_len_bounds();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
